// File: rtl/axi_arbiter_if.sv
// AXI4-Lite channel bundle (32-bit addr/data, 4-bit write mask, 2-bit responses).
// master drives requests toward a slave; slave is the responder view.
interface axi_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wmask, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wmask, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_arbiter.sv
// Two-master AXI4-Lite arbiter (m0 IFU, m1 LSU) serialising whole transactions onto s; m1 wins ties, or round-robin when ARB_RR_EN is defined.
// Registered grant: request in IDLE -> downstream valid next cycle, one IDLE bubble after each R/B handshake; ungranted masters see no ready.
module axi_arbiter (
  input  logic  clk,
  input  logic  reset,
  axi_if.slave  m0,
  axi_if.slave  m1,
  axi_if.master s
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP
  } state_t;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       winner, win_ar;
  logic [1:0] req;
  logic       own_arvalid, own_rready, own_awvalid, own_wvalid, own_bready;

  assign req = {m1.arvalid | m1.awvalid, m0.arvalid | m0.awvalid};

`ifdef ARB_RR_EN
  logic prio, prio_nxt;
  // prio only matters on contention; a lone requester always wins
  assign winner = (req == 2'b11) ? prio : req[1];
`else
  assign winner = req[1];
`endif

  // a master presenting both AR and AW gets its read served first
  assign win_ar = winner ? m1.arvalid : m0.arvalid;

  assign own_arvalid = owner ? m1.arvalid : m0.arvalid;
  assign own_rready  = owner ? m1.rready  : m0.rready;
  assign own_awvalid = owner ? m1.awvalid : m0.awvalid;
  assign own_wvalid  = owner ? m1.wvalid  : m0.wvalid;
  assign own_bready  = owner ? m1.bready  : m0.bready;

  // payloads default to m0 so the crossbar never sees X when idle
  assign s.araddr = (state == RD_ADDR && owner) ? m1.araddr : m0.araddr;
  assign s.awaddr = (state == WR_ADDR && owner) ? m1.awaddr : m0.awaddr;
  assign s.wdata  = (state == WR_DATA && owner) ? m1.wdata  : m0.wdata;
  assign s.wmask  = (state == WR_DATA && owner) ? m1.wmask  : m0.wmask;

  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;
  assign m0.rresp = s.rresp;
  assign m1.rresp = s.rresp;
  assign m0.bresp = s.bresp;
  assign m1.bresp = s.bresp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio <= 1'b0;
    else       prio <= prio_nxt;
  end
`endif

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
`ifdef ARB_RR_EN
    prio_nxt   = prio;
`endif
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awvalid  = 1'b0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt = winner;
          state_nxt = win_ar ? RD_ADDR : WR_ADDR;
`ifdef ARB_RR_EN
          prio_nxt  = ~winner;
`endif
        end
      end
      RD_ADDR: begin
        s.arvalid  = own_arvalid;
        m0.arready = ~owner & s.arready;
        m1.arready =  owner & s.arready;
        if (own_arvalid && s.arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        s.rready  = own_rready;
        m0.rvalid = ~owner & s.rvalid;
        m1.rvalid =  owner & s.rvalid;
        if (s.rvalid && own_rready) state_nxt = IDLE;
      end
      // W is held back until AW is accepted; the crossbar needs AW first
      WR_ADDR: begin
        s.awvalid  = own_awvalid;
        m0.awready = ~owner & s.awready;
        m1.awready =  owner & s.awready;
        if (own_awvalid && s.awready) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        s.wvalid  = own_wvalid;
        m0.wready = ~owner & s.wready;
        m1.wready =  owner & s.wready;
        if (own_wvalid && s.wready) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        s.bready  = own_bready;
        m0.bvalid = ~owner & s.bvalid;
        m1.bvalid =  owner & s.bvalid;
        if (s.bvalid && own_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_axi_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  axi_if m0_if ();
  axi_if m1_if ();
  axi_if s_if ();

  axi_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    m0_if.araddr = 32'h0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
    m0_if.awaddr = 32'h0; m0_if.awvalid = 1'b0; m0_if.wdata = 32'h0;
    m0_if.wmask = 4'h0;   m0_if.wvalid = 1'b0;  m0_if.bready = 1'b0;
    m1_if.araddr = 32'h0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
    m1_if.awaddr = 32'h0; m1_if.awvalid = 1'b0; m1_if.wdata = 32'h0;
    m1_if.wmask = 4'h0;   m1_if.wvalid = 1'b0;  m1_if.bready = 1'b0;
    s_if.arready = 1'b0;  s_if.rdata = 32'h0;   s_if.rresp = 2'b00;
    s_if.rvalid = 1'b0;   s_if.awready = 1'b0;  s_if.wready = 1'b0;
    s_if.bresp = 2'b00;   s_if.bvalid = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] hs;
    clear_inputs();
    reset = 1'b1;
    m0_if.arvalid = 1'b1; m1_if.awvalid = 1'b1;
    m0_if.rready = 1'b1; m1_if.rready = 1'b1; m0_if.bready = 1'b1; m1_if.bready = 1'b1;
    s_if.arready = 1'b1; s_if.awready = 1'b1; s_if.wready = 1'b1;
    s_if.rvalid = 1'b1; s_if.bvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      hs = {m0_if.arready, m0_if.rvalid, m0_if.awready, m0_if.wready, m0_if.bvalid,
            m1_if.arready, m1_if.rvalid, m1_if.awready, m1_if.wready, m1_if.bvalid,
            s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid, s_if.bready};
      n_cmp++; if (hs !== 15'h0) begin n_err++; $display("FAIL reset_hold_handshakes: got %h want 0", hs); end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    hs = {m0_if.arready, m0_if.rvalid, m0_if.awready, m0_if.wready, m0_if.bvalid,
          m1_if.arready, m1_if.rvalid, m1_if.awready, m1_if.wready, m1_if.bvalid,
          s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid, s_if.bready};
    n_cmp++; if (hs !== 15'h0) begin n_err++; $display("FAIL reset_release_handshakes: got %h want 0", hs); end
  endtask

  task automatic test_lone_read();
    apply_reset();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0000; m0_if.rready = 1'b1;
    m1_if.rready = 1'b1; s_if.arready = 1'b1;
    #1;
    n_cmp++; if (s_if.arvalid !== 1'b0) begin n_err++; $display("FAIL lone_idle_arvalid: got %b want 0", s_if.arvalid); end
    n_cmp++; if (m0_if.arready !== 1'b0) begin n_err++; $display("FAIL lone_idle_arready: got %b want 0", m0_if.arready); end
    @(negedge clk); #1;
    n_cmp++; if (s_if.arvalid !== 1'b1) begin n_err++; $display("FAIL lone_s_arvalid: got %b want 1", s_if.arvalid); end
    n_cmp++; if (s_if.araddr !== 32'h8000_0000) begin n_err++; $display("FAIL lone_s_araddr: got %h want 80000000", s_if.araddr); end
    n_cmp++; if (m0_if.arready !== 1'b1) begin n_err++; $display("FAIL lone_m0_arready: got %b want 1", m0_if.arready); end
    n_cmp++; if (m1_if.rvalid !== 1'b0) begin n_err++; $display("FAIL lone_m1_rvalid_a: got %b want 0", m1_if.rvalid); end
    @(negedge clk);
    m0_if.arvalid = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'h1234_5678; s_if.rresp = 2'b00;
    #1;
    n_cmp++; if (m0_if.rvalid !== 1'b1) begin n_err++; $display("FAIL lone_m0_rvalid: got %b want 1", m0_if.rvalid); end
    n_cmp++; if (m0_if.rdata !== 32'h1234_5678) begin n_err++; $display("FAIL lone_m0_rdata: got %h want 12345678", m0_if.rdata); end
    n_cmp++; if (m1_if.rvalid !== 1'b0) begin n_err++; $display("FAIL lone_m1_rvalid_b: got %b want 0", m1_if.rvalid); end
    n_cmp++; if (s_if.rready !== 1'b1) begin n_err++; $display("FAIL lone_s_rready: got %b want 1", s_if.rready); end
    n_cmp++; if (s_if.arvalid !== 1'b0) begin n_err++; $display("FAIL lone_s_arvalid_rd: got %b want 0", s_if.arvalid); end
    @(negedge clk); #1;
    n_cmp++; if (m0_if.rvalid !== 1'b0) begin n_err++; $display("FAIL lone_done_m0_rvalid: got %b want 0", m0_if.rvalid); end
    n_cmp++; if (s_if.rready !== 1'b0) begin n_err++; $display("FAIL lone_done_s_rready: got %b want 0", s_if.rready); end
    s_if.rvalid = 1'b0;
  endtask

  task automatic test_contention();
    logic        fst;
    logic [31:0] fst_addr, snd_addr;
`ifdef ARB_RR_EN
    fst = 1'b0;
`else
    fst = 1'b1;
`endif
    fst_addr = fst ? 32'h8000_0010 : 32'h8000_0000;
    snd_addr = fst ? 32'h8000_0000 : 32'h8000_0010;
    apply_reset();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0000; m0_if.rready = 1'b1;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h8000_0010; m1_if.rready = 1'b1;
    s_if.arready = 1'b1;
    #1;
    n_cmp++; if ({m1_if.arready, m0_if.arready} !== 2'b00) begin n_err++; $display("FAIL cont_idle_arready: got %b want 00", {m1_if.arready, m0_if.arready}); end
    @(negedge clk); #1;
    n_cmp++; if (s_if.araddr !== fst_addr) begin n_err++; $display("FAIL cont_first_araddr: got %h want %h", s_if.araddr, fst_addr); end
    n_cmp++; if ({m1_if.arready, m0_if.arready} !== (fst ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL cont_first_arready: got %b want %b", {m1_if.arready, m0_if.arready}, fst ? 2'b10 : 2'b01); end
    @(negedge clk);
    if (fst) m1_if.arvalid = 1'b0; else m0_if.arvalid = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_00a1;
    #1;
    n_cmp++; if ({m1_if.rvalid, m0_if.rvalid} !== (fst ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL cont_first_rvalid: got %b want %b", {m1_if.rvalid, m0_if.rvalid}, fst ? 2'b10 : 2'b01); end
    n_cmp++; if ({m1_if.arready, m0_if.arready} !== 2'b00) begin n_err++; $display("FAIL cont_loser_wait: got %b want 00", {m1_if.arready, m0_if.arready}); end
    @(negedge clk);
    s_if.rvalid = 1'b0;
    #1;
    n_cmp++; if (s_if.arvalid !== 1'b0) begin n_err++; $display("FAIL cont_bubble_arvalid: got %b want 0", s_if.arvalid); end
    @(negedge clk); #1;
    n_cmp++; if (s_if.arvalid !== 1'b1) begin n_err++; $display("FAIL cont_second_arvalid: got %b want 1", s_if.arvalid); end
    n_cmp++; if (s_if.araddr !== snd_addr) begin n_err++; $display("FAIL cont_second_araddr: got %h want %h", s_if.araddr, snd_addr); end
    @(negedge clk);
    m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_00b2;
    #1;
    n_cmp++; if ({m1_if.rvalid, m0_if.rvalid} !== (fst ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL cont_second_rvalid: got %b want %b", {m1_if.rvalid, m0_if.rvalid}, fst ? 2'b01 : 2'b10); end
    @(negedge clk);
    s_if.rvalid = 1'b0;
  endtask

  task automatic test_write();
    apply_reset();
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'ha000_03f8;
    m1_if.wvalid = 1'b1; m1_if.wdata = 32'h0000_0041; m1_if.wmask = 4'b0001;
    m1_if.bready = 1'b1;
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    #1;
    n_cmp++; if ({s_if.awvalid, s_if.wvalid} !== 2'b00) begin n_err++; $display("FAIL wr_idle_valids: got %b want 00", {s_if.awvalid, s_if.wvalid}); end
    @(negedge clk); #1;
    n_cmp++; if ({s_if.awvalid, s_if.wvalid} !== 2'b10) begin n_err++; $display("FAIL wr_addr_valids: got %b want 10", {s_if.awvalid, s_if.wvalid}); end
    n_cmp++; if (s_if.awaddr !== 32'ha000_03f8) begin n_err++; $display("FAIL wr_awaddr: got %h want a00003f8", s_if.awaddr); end
    n_cmp++; if ({m1_if.awready, m1_if.wready} !== 2'b10) begin n_err++; $display("FAIL wr_addr_readies: got %b want 10", {m1_if.awready, m1_if.wready}); end
    @(negedge clk);
    m1_if.awvalid = 1'b0;
    #1;
    n_cmp++; if ({s_if.awvalid, s_if.wvalid} !== 2'b01) begin n_err++; $display("FAIL wr_data_valids: got %b want 01", {s_if.awvalid, s_if.wvalid}); end
    n_cmp++; if (s_if.wdata !== 32'h0000_0041) begin n_err++; $display("FAIL wr_wdata: got %h want 00000041", s_if.wdata); end
    n_cmp++; if (s_if.wmask !== 4'b0001) begin n_err++; $display("FAIL wr_wmask: got %b want 0001", s_if.wmask); end
    n_cmp++; if (m1_if.wready !== 1'b1) begin n_err++; $display("FAIL wr_m1_wready: got %b want 1", m1_if.wready); end
    @(negedge clk);
    m1_if.wvalid = 1'b0;
    s_if.bvalid = 1'b1; s_if.bresp = 2'b10;
    #1;
    n_cmp++; if ({m1_if.bvalid, m0_if.bvalid} !== 2'b10) begin n_err++; $display("FAIL wr_bvalid: got %b want 10", {m1_if.bvalid, m0_if.bvalid}); end
    n_cmp++; if (m1_if.bresp !== 2'b10) begin n_err++; $display("FAIL wr_bresp: got %b want 10", m1_if.bresp); end
    n_cmp++; if (s_if.bready !== 1'b1) begin n_err++; $display("FAIL wr_s_bready: got %b want 1", s_if.bready); end
    @(negedge clk); #1;
    n_cmp++; if ({m1_if.bvalid, s_if.bready, s_if.awvalid} !== 3'b000) begin n_err++; $display("FAIL wr_done_idle: got %b want 000", {m1_if.bvalid, s_if.bready, s_if.awvalid}); end
    s_if.bvalid = 1'b0;
  endtask

  task automatic test_read_before_write();
    apply_reset();
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h8000_0020; m1_if.rready = 1'b1;
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h8000_0024; m1_if.bready = 1'b1;
    s_if.arready = 1'b1; s_if.awready = 1'b1; s_if.wready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({s_if.arvalid, s_if.awvalid} !== 2'b10) begin n_err++; $display("FAIL rw_first_ar: got %b want 10", {s_if.arvalid, s_if.awvalid}); end
    @(negedge clk);
    m1_if.arvalid = 1'b0;
    s_if.rvalid = 1'b1;
    #1;
    n_cmp++; if ({m1_if.rvalid, s_if.awvalid} !== 2'b10) begin n_err++; $display("FAIL rw_rdata_phase: got %b want 10", {m1_if.rvalid, s_if.awvalid}); end
    @(negedge clk);
    s_if.rvalid = 1'b0;
    #1;
    n_cmp++; if (s_if.awvalid !== 1'b0) begin n_err++; $display("FAIL rw_bubble_awvalid: got %b want 0", s_if.awvalid); end
    @(negedge clk); #1;
    n_cmp++; if ({s_if.arvalid, s_if.awvalid} !== 2'b01) begin n_err++; $display("FAIL rw_then_aw: got %b want 01", {s_if.arvalid, s_if.awvalid}); end
    n_cmp++; if (s_if.awaddr !== 32'h8000_0024) begin n_err++; $display("FAIL rw_awaddr: got %h want 80000024", s_if.awaddr); end
    @(negedge clk);
    m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b1;
    @(negedge clk);
    m1_if.wvalid = 1'b0; s_if.bvalid = 1'b1;
    @(negedge clk);
    s_if.bvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   grants;
    int   n0;
    int   n1;
    logic exp_w;
    logic got_w;
    grants = 0; n0 = 0; n1 = 0;
    apply_reset();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0100; m0_if.rready = 1'b1;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h8000_0200; m1_if.rready = 1'b1;
    s_if.arready = 1'b1; s_if.rvalid = 1'b1;
    for (int cyc = 0; cyc < 60 && grants < 8; cyc++) begin
      #1;
      if (m0_if.arready || m1_if.arready) begin
`ifdef ARB_RR_EN
        exp_w = grants[0];
`else
        exp_w = 1'b1;
`endif
        got_w = m1_if.arready;
        n_cmp++; if ({m1_if.arready, m0_if.arready} !== (exp_w ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL b2b_grant%0d: got %b want %b", grants, {m1_if.arready, m0_if.arready}, exp_w ? 2'b10 : 2'b01); end
        if (got_w) n1++; else n0++;
        grants++;
      end
      @(negedge clk);
    end
    n_cmp++; if (grants !== 8) begin n_err++; $display("FAIL b2b_grant_count: got %0d want 8", grants); end
`ifdef ARB_RR_EN
    n_cmp++; if (n0 !== 4 || n1 !== 4) begin n_err++; $display("FAIL b2b_split: got m0=%0d m1=%0d want 4/4", n0, n1); end
`else
    n_cmp++; if (n0 !== 0 || n1 !== 8) begin n_err++; $display("FAIL b2b_split: got m0=%0d m1=%0d want 0/8", n0, n1); end
`endif
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0030; m0_if.rready = 1'b1;
    m1_if.rready = 1'b1; s_if.arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m0_if.arvalid = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'hdead_beef;
    #1;
    n_cmp++; if (m0_if.rvalid !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_rvalid: got %b want 1", m0_if.rvalid); end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if ({m1_if.rvalid, m0_if.rvalid, s_if.rready} !== 3'b000) begin n_err++; $display("FAIL rst_mid_drop: got %b want 000", {m1_if.rvalid, m0_if.rvalid, s_if.rready}); end
    @(negedge clk);
    reset = 1'b0;
    s_if.rvalid = 1'b0;
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0040;
    #1;
    n_cmp++; if (s_if.arvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: got %b want 0", s_if.arvalid); end
    @(negedge clk); #1;
    n_cmp++; if (s_if.arvalid !== 1'b1) begin n_err++; $display("FAIL rst_mid_regrant: got %b want 1", s_if.arvalid); end
    n_cmp++; if (s_if.araddr !== 32'h8000_0040) begin n_err++; $display("FAIL rst_mid_araddr: got %h want 80000040", s_if.araddr); end
    @(negedge clk);
    m0_if.arvalid = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'h0000_0777;
    #1;
    n_cmp++; if (m0_if.rdata !== 32'h0000_0777 || m0_if.rvalid !== 1'b1) begin n_err++; $display("FAIL rst_mid_new_rdata: got %h/%b want 00000777/1", m0_if.rdata, m0_if.rvalid); end
    @(negedge clk);
    s_if.rvalid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_lone_read();
    test_contention();
    test_write();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
